// File: rtl/intr_ctrl_if.sv
`default_nettype none
// ============================================================================
// intr_ctrl_if
//   Request-line, mask-write and CPU handshake bundle for intr_ctrl.
//   Rev 1.0 - initial release
// ============================================================================
interface intr_ctrl_if #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 3
);
  logic [N_SRC-1:0] irq_in;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             int_ack;
  logic             int_sig;
  logic [ID_W-1:0]  int_id;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;

  // master: the environment (request sources, software, CPU control unit)
  modport master (
    output irq_in, mask_we, mask_wdata, int_ack,
    input  int_sig, int_id, pending, mask
  );

  // slave: the interrupt controller
  modport slave (
    input  irq_in, mask_we, mask_wdata, int_ack,
    output int_sig, int_id, pending, mask
  );
endinterface
`default_nettype wire

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// intr_ctrl
//   Synchronises and edge-latches N_SRC request lines, masks them, and offers
//   one fixed-priority interrupt at a time to the CPU with an ack/gap handshake.
//   Rev 1.0 - initial release
// ============================================================================
module intr_ctrl #(
  parameter int N_SRC       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_GAP     = 2,
  parameter int ID_W        = 3
) (
  input  logic        clk,
  input  logic        rstn,
  intr_ctrl_if.slave  bus
);

  localparam int             CNT_W      = 4;
  localparam logic [CNT_W-1:0] C_GAP_LOAD = CNT_W'(MIN_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
  logic [N_SRC-1:0]                  s_d_q;
  logic [N_SRC-1:0]                  pending_q;
  logic [N_SRC-1:0]                  pending_d;
  logic [N_SRC-1:0]                  mask_q;
  logic [N_SRC-1:0]                  mask_d;
  state_t                            state_q;
  logic                              int_sig_q;
  logic [ID_W-1:0]                   int_id_q;
  logic [CNT_W-1:0]                  gap_q;

  logic [N_SRC-1:0]                  w_sync;
  logic [N_SRC-1:0]                  w_rise;
  logic [N_SRC-1:0]                  w_elig;
  logic [N_SRC-1:0]                  w_clr;
  logic [ID_W-1:0]                   w_win_id;
  logic                              w_take;

  // sync_q[0] is the newest sample; the oldest stage is the synchronised line
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      s_d_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
      s_d_q  <= w_sync;
    end
  end

  assign w_sync = sync_q[SYNC_STAGES-1];
  assign w_rise = w_sync & ~s_d_q;
  assign w_elig = pending_q & mask_q;
  assign w_take = (state_q == S_REQ) && bus.int_ack;

  always_comb begin
    w_win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_win_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_clr[i] = w_take && (int_id_q == ID_W'(i));
    end
  end

  // A fresh rise overrides the ack clear on the same bit
  assign pending_d = (pending_q & ~w_clr) | w_rise;
  assign mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_q <= '0;
      mask_q    <= '1;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      int_sig_q <= 1'b0;
      int_id_q  <= '0;
      gap_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|w_elig) begin
            int_id_q  <= w_win_id;
            int_sig_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.int_ack) begin
            int_sig_q <= 1'b0;
            state_q   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!bus.int_ack) begin
            gap_q   <= C_GAP_LOAD;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.int_sig = int_sig_q;
  assign bus.int_id  = int_id_q;
  assign bus.pending = pending_q;
  assign bus.mask    = mask_q;

endmodule
`default_nettype wire

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller that sits directly upstream of the pipelined CPU and drives its `int_sig` input. It synchronises up to eight asynchronous external request lines and latches rising edges into a pending register. It applies a software-written enable mask and presents one request at a time to the CPU, highest priority first. A request/acknowledge handshake and a programmable minimum gap between consecutive interrupts keep the control unit's interrupt-injection sequence from being re-triggered.

## Interface
- `N_SRC`, 4: number of request lines, legal range 2..8.
- `SYNC_STAGES`, 2: flip-flops per request-line synchroniser, legal range 2..3.
- `MIN_GAP`, 2: idle cycles enforced after the acknowledge drops, legal range 1..15.
- `ID_W`, 3: width of `int_id`; must satisfy 2^ID_W >= N_SRC.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `irq_in`  in  N_SRC  asynchronous external request lines; a rising edge raises a request.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_wdata`  in  N_SRC  new mask value; bit = 1 enables that source.
- `int_ack`  in  1  from the CPU control unit; high while the interrupt sequence is being taken.
- `int_sig`  out  1  interrupt request to the CPU.
- `int_id`  out  ID_W  index of the source being served; stable while `int_sig` = 1.
- `pending`  out  N_SRC  current pending register, for debug and status reads.
- `mask`  out  N_SRC  current mask register.

## Operation
- **Reset values:**
  - All synchroniser flops, the edge-history register and `pending` = 0.
  - `mask` = all ones.
  - State = IDLE; `int_sig` = 0; `int_id` = 0; gap counter = 0.
- **Synchroniser:** each `irq_in[i]` passes through a chain of SYNC_STAGES flops. The last flop output is `s[i]`.
- **Edge detect:** `s_d` holds the previous `s`. A rise on bit i is `s[i] & ~s_d[i]`. Level-held lines do not re-request.
- **Pending register:**
  - A rise on bit i sets `pending[i]`.
  - Bit i is cleared only on the acknowledge edge of an interrupt with `int_id` = i.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- **Mask:**
  - `mask_we` = 1 loads `mask_wdata` at the clock edge.
  - Masking never clears pending. A masked pending bit is served once it is re-enabled.
- **Eligibility:** `elig = pending & mask`. Priority is fixed: lowest index wins.
- **FSM:**
  - IDLE: when `elig` != 0, latch the winning index into `int_id`, set `int_sig` = 1 and go to REQ.
  - REQ: hold `int_sig` and `int_id`; mask writes do not withdraw the request. When `int_ack` = 1 at an edge, clear `pending[int_id]`, drive `int_sig` = 0 and go to RELEASE.
  - RELEASE: wait until `int_ack` = 0. At that edge, load the gap counter with MIN_GAP-1 and go to GAP.
  - GAP: decrement the counter each cycle. When it reaches 0, go to IDLE. While in GAP, no new request is issued; `pending` keeps accumulating.
- An `int_ack` pulse seen in IDLE or GAP is ignored: no state change, no clear.
- Reset asserted in any state, including mid-handshake, returns every register to its reset value immediately and asynchronously. Pending requests are lost.

## Timing
- **Pin to `pending`:** the edge that first samples `irq_in[i]` = 1 is edge 0. `s[i]` rises after edge SYNC_STAGES-1. `pending[i]` = 1 after edge SYNC_STAGES.
- **`pending` to `int_sig`:** 1 cycle from IDLE. The default total from pin to `int_sig` is 3 edges.
- **`int_ack` to `int_sig` low:** 1 edge. `pending` is cleared at the same edge.
- **Minimum spacing between requests:** the edge where `int_ack` is seen low, then MIN_GAP edges in GAP, then one IDLE edge before `int_sig` rises again.
- **`int_id`:** changes only on the IDLE to REQ transition.
- **`mask`:** a write takes effect for eligibility in the cycle after `mask_we`.

## Test plan
- **Reset:** hold `rstn` = 0 and toggle `irq_in`. Every output stays at its reset value and `mask` = 0xF. Release reset, pulse `irq_in[2]`. `int_sig` rises 3 edges after the first sampling edge, with `int_id` = 2.
- **Priority:** with `irq_in` = 0, drive 4'b1010 in one cycle. The first request has `int_id` = 1. Ack, then drop the ack. After MIN_GAP + 1 edges a second request has `int_id` = 3. `pending` reads 0 at the end.
- **Masking:** write mask 4'b1110, pulse `irq_in[0]`. `pending[0]` = 1 and `int_sig` stays 0 for 20 cycles. Write mask 4'b1111; `int_sig` rises on the following edge with `int_id` = 0.
- **Set/clear collision:** schedule a new rise on `irq_in[1]` so the `pending[1]` set lands on the ack edge of `int_id` = 1. `pending[1]` stays 1 and a second request with `int_id` = 1 follows after the gap.
- **Long ack:** hold `int_ack` high for 5 cycles while source 3 is pending. There is no second request until `int_ack` falls plus the MIN_GAP + 1 edges. An `int_ack` pulse in IDLE changes nothing.
- **Reset mid-handshake:** assert `rstn` in REQ. `int_sig` drops immediately (asynchronously) and `pending` = 0. After release, no request is issued without a new edge.
